gpr_scoreboard_rf: RTL and testbench

- Parametrised general-purpose register file for the pipelined NPC core.
- Provides N read ports, one writeback port, and x0 hardwired to zero.
- Adds write-to-read bypass and a per-register pending-write scoreboard, so decode can detect RAW hazards and stall.
- Sits between decode/issue (reservations, operand reads) and writeback (result writes).

---
 rtl/gpr_scoreboard_rf_if.sv | 34 +++
 rtl/gpr_scoreboard_rf.sv | 90 +++++++++
 tb/tb_gpr_scoreboard_rf.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/gpr_scoreboard_rf_if.sv
// Bus bundle for the register file: operand reads, destination reservations,
// writeback, and the sticky writeback error flag.
interface gpr_scoreboard_rf_if #(
  parameter int GPR_ADDR_WIDTH = 5,
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_RPORTS     = 2
);
  // Reservation handshake: a reservation of rsv_addr takes effect on the
  // rising clock edge where rsv_valid && rsv_ready are both 1. rsv_ready is a
  // look-ahead that is driven even while rsv_valid=0. Once issue raises
  // rsv_valid it holds rsv_valid and rsv_addr stable until it sees rsv_ready.
  // Writeback has no back-pressure: wb_valid is always accepted.
  logic [NUM_RPORTS-1:0]                rd_en;
  logic [NUM_RPORTS*GPR_ADDR_WIDTH-1:0] rd_addr;
  logic [NUM_RPORTS*DATA_WIDTH-1:0]     rd_data;
  logic [NUM_RPORTS-1:0]                rd_ready;
  logic                                 rsv_valid;
  logic [GPR_ADDR_WIDTH-1:0]            rsv_addr;
  logic                                 rsv_ready;
  logic                                 wb_valid;
  logic [GPR_ADDR_WIDTH-1:0]            wb_addr;
  logic [DATA_WIDTH-1:0]                wb_data;
  logic                                 wb_err;

  modport master (
    output rd_en, rd_addr, rsv_valid, rsv_addr, wb_valid, wb_addr, wb_data,
    input  rd_data, rd_ready, rsv_ready, wb_err
  );

  modport slave (
    input  rd_en, rd_addr, rsv_valid, rsv_addr, wb_valid, wb_addr, wb_data,
    output rd_data, rd_ready, rsv_ready, wb_err
  );
endinterface

// File: rtl/gpr_scoreboard_rf.sv
// GPR file with x0 hardwired to zero, writeback-to-read bypass, and per-register
// pending-write counters that decode uses to detect RAW hazards.
module gpr_scoreboard_rf #(
  parameter int GPR_ADDR_WIDTH = 5,
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_RPORTS     = 2,
  parameter int CNT_WIDTH      = 2
) (
  input  logic               clk,
  input  logic               rst,
  gpr_scoreboard_rf_if.slave bus
);
  localparam int AW    = GPR_ADDR_WIDTH;
  localparam int DW    = DATA_WIDTH;
  localparam int NREGS = 1 << AW;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  logic [DW-1:0]        regs_q [NREGS];
  logic [CNT_WIDTH-1:0] cnt_q  [NREGS];
  logic [CNT_WIDTH-1:0] cnt_d  [NREGS];
  logic                 wb_err_q, wb_err_d;

  logic wb_act, rsv_act, rsv_ready, rsv_acc;
  logic [NUM_RPORTS*DW-1:0] rd_data;
  logic [NUM_RPORTS-1:0]    rd_ready;

  // x0 is excluded here, so it is never written and never counted.
  assign wb_act  = bus.wb_valid  && (bus.wb_addr  != '0);
  assign rsv_act = bus.rsv_valid && (bus.rsv_addr != '0);

  // A full counter can still accept a reservation when a writeback to the same
  // register retires one in the same cycle.
  assign rsv_ready = (bus.rsv_addr == '0) ||
                     (cnt_q[bus.rsv_addr] != CNT_MAX) ||
                     (wb_act && (bus.wb_addr == bus.rsv_addr));
  assign rsv_acc   = rsv_act && rsv_ready;

  always_comb begin
    logic inc, dec;
    cnt_d    = cnt_q;
    wb_err_d = wb_err_q;
    inc      = 1'b0;
    dec      = 1'b0;
    if (wb_act && (cnt_q[bus.wb_addr] == '0)) wb_err_d = 1'b1;
    for (int r = 1; r < NREGS; r++) begin
      inc = rsv_acc && (bus.rsv_addr == AW'(r));
      dec = wb_act && (bus.wb_addr == AW'(r)) && (cnt_q[r] != '0);
      if (inc && !dec)      cnt_d[r] = cnt_q[r] + CNT_WIDTH'(1);
      else if (dec && !inc) cnt_d[r] = cnt_q[r] - CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) begin
        regs_q[r] <= '0;
        cnt_q[r]  <= '0;
      end
      wb_err_q <= 1'b0;
    end else begin
      if (wb_act) regs_q[bus.wb_addr] <= bus.wb_data;
      cnt_q    <= cnt_d;
      wb_err_q <= wb_err_d;
    end
  end

  always_comb begin
    logic [AW-1:0] a;
    rd_data  = '0;
    rd_ready = '1;
    a        = '0;
    for (int i = 0; i < NUM_RPORTS; i++) begin
      a = bus.rd_addr[i*AW +: AW];
      if (bus.rd_en[i] && (a != '0)) begin
        if (wb_act && (bus.wb_addr == a)) begin
          rd_data[i*DW +: DW] = bus.wb_data;
          rd_ready[i]         = (cnt_q[a] <= CNT_WIDTH'(1));
        end else begin
          rd_data[i*DW +: DW] = regs_q[a];
          rd_ready[i]         = (cnt_q[a] == '0);
        end
      end
    end
  end

  assign bus.rd_data   = rd_data;
  assign bus.rd_ready  = rd_ready;
  assign bus.rsv_ready = rsv_ready;
  assign bus.wb_err    = wb_err_q;
endmodule

// File: tb/tb_gpr_scoreboard_rf.sv
// Randomised and directed check of gpr_scoreboard_rf against an array-based
// model of register contents and outstanding-write counts.
module tb_gpr_scoreboard_rf;
  localparam int AW   = 5;
  localparam int DW   = 32;
  localparam int NRP  = 2;
  localparam int CW   = 2;
  localparam int MAXP = (1 << CW) - 1;
  localparam int W    = NRP*DW + NRP + 2;

  logic clk, rst;
  gpr_scoreboard_rf_if #(.GPR_ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RPORTS(NRP)) bus ();

  gpr_scoreboard_rf #(.GPR_ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RPORTS(NRP), .CNT_WIDTH(CW))
    dut (.clk(clk), .rst(rst), .bus(bus));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: contents, outstanding writes per register, sticky error
  logic [DW-1:0] m_reg [32];
  int            m_pend[32];
  bit            m_err;

  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  // driver: apply one cycle of inputs, queue the expected outputs, advance model
  task automatic drive(input bit r, input logic [1:0] en, input logic [AW-1:0] a0,
                       input logic [AW-1:0] a1, input bit rv, input logic [AW-1:0] ra,
                       input bit wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input bit chk);
    logic [DW-1:0] d [NRP];
    logic [NRP-1:0] rdy;
    logic [AW-1:0] a;
    bit rsv_ok;
    rst           = r;
    bus.rd_en     = en;
    bus.rd_addr   = {a1, a0};
    bus.rsv_valid = rv;
    bus.rsv_addr  = ra;
    bus.wb_valid  = wv;
    bus.wb_addr   = wa;
    bus.wb_data   = wd;
    for (int i = 0; i < NRP; i++) begin
      a = (i == 0) ? a0 : a1;
      if (!en[i] || a == 0) begin
        d[i] = '0; rdy[i] = 1'b1;
      end else if (wv && wa == a) begin
        d[i] = wd; rdy[i] = (m_pend[a] <= 1);
      end else begin
        d[i] = m_reg[a]; rdy[i] = (m_pend[a] == 0);
      end
    end
    rsv_ok = (ra == 0) || (m_pend[ra] < MAXP) || (wv && wa == ra);
    if (chk) exp_q.push_back({d[1], d[0], rdy, rsv_ok, m_err});
    if (r) begin
      for (int k = 0; k < 32; k++) begin m_reg[k] = '0; m_pend[k] = 0; end
      m_err = 1'b0;
    end else begin
      if (wv && wa != 0) begin
        m_reg[wa] = wd;
        if (m_pend[wa] == 0) m_err = 1'b1;
        else m_pend[wa] = m_pend[wa] - 1;
      end
      if (rv && ra != 0 && rsv_ok) m_pend[ra] = m_pend[ra] + 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    drive(0, 2'b11, a0, a1, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at t=%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // monitor: outputs are combinational, so sample mid-cycle
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      cmp("rd_data",   {bus.rd_data},         e[W-1:NRP+2]);
      cmp("rd_ready",  {62'd0, bus.rd_ready}, {62'd0, e[NRP+1:2]});
      cmp("rsv_ready", {63'd0, bus.rsv_ready}, {63'd0, e[1]});
      cmp("wb_err",    {63'd0, bus.wb_err},    {63'd0, e[0]});
    end
  end

  initial begin
    for (int k = 0; k < 32; k++) begin m_reg[k] = '0; m_pend[k] = 0; end
    m_err = 1'b0;
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 2'b11, 1, 2, 0, 0, 0, 0, 0, 1);
    for (int r = 0; r < 32; r++) rd(AW'(r), AW'(31 - r));

    // single reservation, bypassed writeback
    drive(0, 2'b11, 5, 5, 1, 5, 0, 0, 0, 1);
    rd(5, 0);
    drive(0, 2'b11, 5, 5, 0, 0, 1, 5, 32'hDEADBEEF, 1);
    rd(5, 5);

    // saturate x7, then full-counter reservation with a same-cycle writeback
    for (int k = 0; k < 3; k++) drive(0, 2'b01, 7, 0, 1, 7, 0, 0, 0, 1);
    drive(0, 2'b11, 7, 7, 1, 7, 0, 0, 0, 1);
    drive(0, 2'b11, 7, 7, 1, 7, 1, 7, 32'h77, 1);
    for (int k = 0; k < 3; k++) drive(0, 2'b11, 7, 7, 1, 7, 1, 7, 32'h70 + k, 0);
    for (int k = 0; k < 3; k++) drive(0, 2'b11, 7, 7, 0, 0, 1, 7, 32'h80 + k, 1);
    rd(7, 7);
    drive(0, 2'b11, 7, 7, 1, 7, 0, 0, 0, 1);

    // x0 is inert
    drive(0, 2'b11, 0, 0, 1, 0, 1, 0, 32'h1234, 1);
    rd(0, 0);

    // writeback with no reservation sets the sticky error
    drive(0, 2'b11, 9, 9, 0, 0, 1, 9, 32'hA5A5, 1);
    rd(9, 0);
    rd(9, 1);

    // reset wins over a concurrent writeback and reservation
    drive(0, 2'b01, 3, 0, 1, 3, 0, 0, 0, 1);
    drive(0, 2'b01, 3, 0, 1, 3, 1, 3, 32'h55, 1);
    rd(3, 3);
    drive(1, 2'b11, 3, 3, 1, 3, 1, 3, 32'h99, 1);
    rd(3, 9);

    // random traffic concentrated on a few registers to create hazards
    for (int n = 0; n < 600; n++) begin
      drive(($urandom_range(0, 63) == 0), 2'($urandom_range(0, 3)),
            AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), $urandom(), 1);
    end

    for (int k = 0; k < 20 && exp_q.size() > 0; k++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
